aes_round_ctrl: RTL and testbench

//  Iterative AES-128 encryption controller. Accepts one 128-bit plaintext and
//  key per handshake, then sequences the shared SubBytes/ShiftRows/MixColumns/

---
 rtl/aes_round_ctrl_pkg.sv | 107 ++++++++++
 rtl/aes_round_ctrl_key_step.sv | 35 +++
 rtl/aes_round_ctrl.sv | 115 +++++++++++
 tb/tb_aes_round_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_round_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : aes_round_ctrl_pkg
// Purpose  : Shared FSM encodings, S-box, RCON and AES round helper functions.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package aes_round_ctrl_pkg;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ROUND = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    localparam int c_NUM_ROUNDS_DEFAULT = 10;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return c_SBOX[(255 - int'(x)) * 8 +: 8];
    endfunction

    // Round constant for the key step that produces round key 'rnd' (1..10).
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r;
        case (rnd)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[i*8 +: 8] = sbox(s[i*8 +: 8]);
        end
        return r;
    endfunction

    // Byte b (FIPS order, row = b%4, column = b/4) lives at bits [(15-b)*8 +: 8].
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[(15 - (w + 4*c)) * 8 +: 8] = s[(15 - (w + 4*((c + w) % 4))) * 8 +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[(15 - 4*c) * 8 +: 8];
            a1 = s[(14 - 4*c) * 8 +: 8];
            a2 = s[(13 - 4*c) * 8 +: 8];
            a3 = s[(12 - 4*c) * 8 +: 8];
            r[(15 - 4*c) * 8 +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[(14 - 4*c) * 8 +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[(13 - 4*c) * 8 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[(12 - 4*c) * 8 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_round_ctrl_key_step.sv
//------------------------------------------------------------------------------
// Module   : aes_key_step
// Purpose  : Combinational AES-128 next-round-key generation (one expansion step).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module aes_key_step
    import aes_round_ctrl_pkg::*;
(
    input  logic [127:0] i_rk,
    input  logic [3:0]   i_round,
    output logic [127:0] o_rk_next
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_w4, w_w5, w_w6, w_w7;
    logic [31:0] w_rot;

    assign w_w0 = i_rk[127:96];
    assign w_w1 = i_rk[95:64];
    assign w_w2 = i_rk[63:32];
    assign w_w3 = i_rk[31:0];

    assign w_rot = {w_w3[23:0], w_w3[31:24]};
    assign w_w4  = w_w0 ^ sub_word(w_rot) ^ {rcon(i_round), 24'h0};
    assign w_w5  = w_w4 ^ w_w1;
    assign w_w6  = w_w5 ^ w_w2;
    assign w_w7  = w_w6 ^ w_w3;

    assign o_rk_next = {w_w4, w_w5, w_w6, w_w7};

endmodule

`default_nettype wire

// File: rtl/aes_round_ctrl.sv
//------------------------------------------------------------------------------
// Module   : aes_round_ctrl
// Purpose  : Iterative AES-128 encryption controller, one round per clock.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module aes_round_ctrl
    import aes_round_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = c_NUM_ROUNDS_DEFAULT,
    parameter bit ZEROIZE    = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy
);

    logic [1:0]   r_fsm;
    logic [1:0]   w_fsm_next;
    logic [3:0]   r_round;
    logic [127:0] r_state;
    logic [127:0] r_rk;
    logic [127:0] r_ct;
    logic         r_out_valid;

    logic         w_accept;
    logic         w_last;
    logic         w_out_hs;
    logic [127:0] w_rk_next;
    logic [127:0] w_sr;
    logic [127:0] w_mix;
    logic [127:0] w_state_next;

    aes_key_step u_key_step (
        .i_rk      (r_rk),
        .i_round   (r_round),
        .o_rk_next (w_rk_next)
    );

    // Final round skips MixColumns.
    assign w_sr         = shift_rows(sub_bytes(r_state));
    assign w_mix        = (r_round == 4'(NUM_ROUNDS)) ? w_sr : mix_columns(w_sr);
    assign w_state_next = w_mix ^ w_rk_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= c_ST_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            c_ST_IDLE:  if (w_accept) w_fsm_next = c_ST_ROUND;
            c_ST_ROUND: if (w_last)   w_fsm_next = c_ST_DONE;
            c_ST_DONE:  if (w_out_hs) w_fsm_next = c_ST_IDLE;
            default:    w_fsm_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_fsm == c_ST_IDLE);
        busy     = (r_fsm == c_ST_ROUND) || (r_fsm == c_ST_DONE);
        w_accept = (r_fsm == c_ST_IDLE) && in_valid;
        w_last   = (r_fsm == c_ST_ROUND) && (r_round == 4'(NUM_ROUNDS));
        w_out_hs = (r_fsm == c_ST_DONE) && r_out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_round     <= 4'd0;
            r_state     <= '0;
            r_rk        <= '0;
            r_ct        <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_state <= plaintext ^ key;
            r_rk    <= key;
            r_round <= 4'd1;
        end else if (r_fsm == c_ST_ROUND) begin
            r_state <= w_state_next;
            r_rk    <= w_rk_next;
            r_round <= r_round + 4'd1;
            if (w_last) begin
                r_ct        <= w_state_next;
                r_out_valid <= 1'b1;
            end
        end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_round     <= 4'd0;
            // Key material must not linger once the result has left the core.
            if (ZEROIZE) begin
                r_ct    <= '0;
                r_state <= '0;
                r_rk    <= '0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign ciphertext = r_ct;

endmodule

`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_aes_round_ctrl
// Purpose  : Self-checking bench for aes_round_ctrl with an AES-128 reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_aes_round_ctrl;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] sb [256];

    aes_round_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b  = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) st[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) st[i] = sb[st[i]];
            for (int i = 0; i < 16; i++) tmp[i] = st[(i % 4) + 4*(((i / 4) + (i % 4)) % 4)];
            for (int c = 0; c < 4; c++) begin
                a0 = tmp[4*c]; a1 = tmp[4*c+1]; a2 = tmp[4*c+2]; a3 = tmp[4*c+3];
                if (r < 10) begin
                    st[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
                    st[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
                end else begin
                    st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = st[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_block(input logic [127:0] pt, input logic [127:0] k,
                             input logic [127:0] exp_ct, input logic [127:0] exp_state,
                             input int stall, input string tag);
        int           cyc;
        logic [127:0] held;
        @(negedge clk);
        plaintext = pt; key = k; in_valid = 1'b1; out_ready = 1'b0;
        chk({tag, ".in_ready_idle"}, 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        plaintext = rnd128();
        key       = rnd128();
        chk({tag, ".busy"}, 128'(busy), 128'd1);
        chk({tag, ".state_after_accept"}, dut.r_state, exp_state);
        wait_out(cyc);
        chk({tag, ".latency"}, 128'(cyc), 128'd10);
        chk({tag, ".ct"}, ciphertext, exp_ct);
        held = ciphertext;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, 128'(out_valid), 128'd1);
            chk({tag, ".hold_ct"}, ciphertext, held);
            chk({tag, ".hold_in_ready"}, 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".post_valid"}, 128'(out_valid), 128'd0);
        chk({tag, ".post_in_ready"}, 128'(in_ready), 128'd1);
        chk({tag, ".post_ct_zero"}, ciphertext, 128'd0);
        chk({tag, ".post_busy"}, 128'(busy), 128'd0);
    endtask

    // ---------------- stimulus ----------------
    localparam logic [127:0] c_KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        logic [127:0] pt_a, k_a, pt_b, k_b;
        int           cyc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        plaintext = '0; key = '0;
        build_sbox();

        repeat (2) @(posedge clk);
        #1;
        chk("reset.in_ready", 128'(in_ready), 128'd1);
        chk("reset.out_valid", 128'(out_valid), 128'd0);
        chk("reset.ct", ciphertext, 128'd0);
        chk("reset.busy", 128'(busy), 128'd0);
        chk("reset.state", dut.r_state, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // FIPS-197 App B (with state probe) and App C.1, the latter with backpressure
        run_block(c_PT_B, c_KEY_B, c_CT_B, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 0, "appB");
        run_block(c_PT_C, c_KEY_C, c_CT_C, c_PT_C ^ c_KEY_C, 5, "appC");

        // Randomized blocks against the model
        for (int n = 0; n < 5; n++) begin
            pt_a = rnd128();
            k_a  = rnd128();
            run_block(pt_a, k_a, aes_ref(pt_a, k_a), pt_a ^ k_a, int'($urandom_range(0, 3)), "rand");
        end

        // Reset mid-operation
        @(negedge clk);
        plaintext = c_PT_B; key = c_KEY_B; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort.out_valid", 128'(out_valid), 128'd0);
        chk("abort.ct", ciphertext, 128'd0);
        chk("abort.busy", 128'(busy), 128'd0);
        chk("abort.in_ready", 128'(in_ready), 128'd1);
        chk("abort.state", dut.r_state, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        run_block(c_PT_B, c_KEY_B, c_CT_B, c_PT_B ^ c_KEY_B, 1, "after_abort");

        // in_valid held high with churning data while busy
        pt_a = rnd128(); k_a = rnd128();
        pt_b = rnd128(); k_b = rnd128();
        @(negedge clk);
        plaintext = pt_a; key = k_a; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            plaintext = rnd128(); key = rnd128();
            @(posedge clk); #1;
            cyc++;
        end
        chk("hold.latency_a", 128'(cyc), 128'd10);
        chk("hold.ct_a", ciphertext, aes_ref(pt_a, k_a));
        chk("hold.in_ready_done", 128'(in_ready), 128'd0);
        plaintext = pt_b; key = k_b; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold.no_accept_on_hs", 128'(in_ready), 128'd1);
        chk("hold.busy_idle", 128'(busy), 128'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("hold.accept_b", 128'(busy), 128'd1);
        chk("hold.state_b", dut.r_state, pt_b ^ k_b);
        wait_out(cyc);
        chk("hold.latency_b", 128'(cyc), 128'd10);
        chk("hold.ct_b", ciphertext, aes_ref(pt_b, k_b));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hold.final_valid", 128'(out_valid), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
